// File: rtl/control_fsm.sv
// control_fsm
//   Multi-cycle instruction sequencer. Fetches an instruction word, decodes
//   it and steps through EXEC / MEM / WB, producing the register-file,
//   ALU, data-memory and PC controls for each step.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   instr_req         fetch request (high whenever in FETCH)
//   instr_valid,instr instruction handshake and 32-bit word
//   mem_ready         data-memory access complete
//   zero              ALU zero flag (BEQ decision)
//   Rs, Rt, Rd        register addresses taken from the latched IR
//   RegFileEnable, RegWR, RegSrc, ALUOp, ALUSrc, imm_ext
//   MemRD, MemWR, WBSel, PCWrite, PCSrc
//   err               sticky: illegal opcode or memory timeout
//   retired           wrapping count of completed instructions
//   state             current FSM state (debug)
//
// Handshakes
//   Fetch: instr_req is high for every FETCH cycle; the word is taken on
//   the first rising edge where instr_valid=1 and there is no backpressure.
//   Memory: MemRD/MemWR stay high every MEM cycle until mem_ready=1 is
//   seen on a rising edge, or until MEM_TIMEOUT cycles have passed without
//   it, after which the request is dropped for one abort cycle.
module control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit IMM_SIGNED  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic        RegFileEnable,
  output logic        RegWR,
  output logic        RegSrc,
  output logic [3:0]  ALUOp,
  output logic        ALUSrc,
  output logic [31:0] imm_ext,
  output logic        MemRD,
  output logic        MemWR,
  output logic        WBSel,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        err,
  output logic [15:0] retired,
  output logic [2:0]  state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_ANDI = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h03;
  localparam logic [5:0] OP_SW   = 6'h04;
  localparam logic [5:0] OP_BEQ  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h06;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [31:0] ir;
  logic [7:0]  wait_cnt;
  logic [2:0]  next_state;
  logic        latch_ir;
  logic        set_err;
  logic        retire;
  logic        clr_cnt;
  logic        inc_cnt;

  logic [5:0]  opcode;
  logic        is_lw;
  logic        is_sw;
  logic [3:0]  dec_alu_op;
  logic        dec_alu_src;

  // Register fields come only from IR, so they hold steady for the whole
  // instruction even while the instr bus changes.
  assign opcode  = ir[31:26];
  assign Rd      = ir[25:21];
  assign Rs      = ir[20:16];
  assign Rt      = ir[15:11];
  assign imm_ext = {{16{ir[15] & IMM_SIGNED}}, ir[15:0]};
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);

  // ALU setup per opcode; applied in every state after FETCH.
  always_comb begin
    dec_alu_op  = 4'd0;
    dec_alu_src = 1'b0;
    case (opcode)
      OP_R:         dec_alu_op  = ir[3:0];
      OP_ADDI:      dec_alu_src = 1'b1;
      OP_ANDI: begin
        dec_alu_op  = 4'd2;
        dec_alu_src = 1'b1;
      end
      OP_LW, OP_SW: dec_alu_src = 1'b1;
      OP_BEQ:       dec_alu_op  = 4'd1;
      default: begin
        dec_alu_op  = 4'd0;
        dec_alu_src = 1'b0;
      end
    endcase
  end

  always_comb begin
    next_state    = state;
    instr_req     = 1'b0;
    RegFileEnable = 1'b0;
    RegWR         = 1'b0;
    RegSrc        = 1'b0;
    ALUOp         = 4'd0;
    ALUSrc        = 1'b0;
    MemRD         = 1'b0;
    MemWR         = 1'b0;
    WBSel         = 1'b0;
    PCWrite       = 1'b0;
    PCSrc         = PC_SEQ;
    latch_ir      = 1'b0;
    set_err       = 1'b0;
    retire        = 1'b0;
    clr_cnt       = 1'b0;
    inc_cnt       = 1'b0;

    case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          latch_ir   = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        RegFileEnable = 1'b1;
        RegSrc        = is_sw;
        ALUOp         = dec_alu_op;
        ALUSrc        = dec_alu_src;
        case (opcode)
          OP_J: begin
            PCWrite    = 1'b1;
            PCSrc      = PC_JUMP;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          OP_R, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ: begin
            next_state = S_EXEC;
          end
          default: begin
            // Illegal opcode: skip it and flag the error, no retirement.
            set_err    = 1'b1;
            PCWrite    = 1'b1;
            PCSrc      = PC_SEQ;
            next_state = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        RegSrc = is_sw;
        ALUOp  = dec_alu_op;
        ALUSrc = dec_alu_src;
        if (opcode == OP_BEQ) begin
          PCWrite    = 1'b1;
          PCSrc      = zero ? PC_BRANCH : PC_SEQ;
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (is_lw || is_sw) begin
          clr_cnt    = 1'b1;
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end

      S_MEM: begin
        // Store data stays routed from Rd for the duration of the access.
        RegSrc = is_sw;
        ALUOp  = dec_alu_op;
        ALUSrc = dec_alu_src;
        if (wait_cnt >= TIMEOUT) begin
          // Abort cycle: the request has already been dropped.
          set_err    = 1'b1;
          PCWrite    = 1'b1;
          PCSrc      = PC_SEQ;
          next_state = S_FETCH;
        end else begin
          MemRD = is_lw;
          MemWR = is_sw;
          if (mem_ready) begin
            if (is_sw) begin
              PCWrite    = 1'b1;
              PCSrc      = PC_SEQ;
              retire     = 1'b1;
              next_state = S_FETCH;
            end else begin
              next_state = S_WB;
            end
          end else begin
            inc_cnt = 1'b1;
          end
        end
      end

      S_WB: begin
        RegFileEnable = 1'b1;
        RegWR         = (Rd != 5'd0);
        WBSel         = is_lw;
        ALUOp         = dec_alu_op;
        ALUSrc        = dec_alu_src;
        PCWrite       = 1'b1;
        PCSrc         = PC_SEQ;
        retire        = 1'b1;
        next_state    = S_FETCH;
      end

      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      ir       <= 32'd0;
      err      <= 1'b0;
      retired  <= 16'd0;
      wait_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (latch_ir) ir <= instr;
      if (set_err) err <= 1'b1;
      if (retire) retired <= retired + 16'd1;
      if (clr_cnt) wait_cnt <= 8'd0;
      else if (inc_cnt) wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  localparam int W  = 82;
  localparam int TO = 15;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, B = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, instr_valid, mem_ready, zero;
  logic [31:0] instr, imm_ext;
  logic [4:0]  Rs, Rt, Rd;
  logic        RegFileEnable, RegWR, RegSrc, ALUSrc, MemRD, MemWR, WBSel, PCWrite, err;
  logic [3:0]  ALUOp;
  logic [1:0]  PCSrc;
  logic [15:0] retired;
  logic [2:0]  state;

  control_fsm #(.MEM_TIMEOUT(TO), .IMM_SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_valid(instr_valid),
    .instr(instr), .mem_ready(mem_ready), .zero(zero), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .RegFileEnable(RegFileEnable), .RegWR(RegWR), .RegSrc(RegSrc), .ALUOp(ALUOp),
    .ALUSrc(ALUSrc), .imm_ext(imm_ext), .MemRD(MemRD), .MemWR(MemWR), .WBSel(WBSel),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .err(err), .retired(retired), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  // ---------------- reference model state ----------------
  logic [31:0] m_ir;
  logic        m_err;
  logic [15:0] m_ret;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ALU controls from the opcode table: {ALUOp, ALUSrc}
  function automatic logic [4:0] alu_of(input logic [31:0] ir);
    case (ir[31:26])
      6'd0:       return {ir[3:0], 1'b0};
      6'd1:       return {4'd0, 1'b1};
      6'd2:       return {4'd2, 1'b1};
      6'd3, 6'd4: return {4'd0, 1'b1};
      6'd5:       return {4'd1, 1'b0};
      default:    return 5'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_vec(input logic [2:0] st, input bit req, input bit rfe,
                                           input bit rwr, input bit rsrc, input bit alu_on,
                                           input bit mrd, input bit mwr, input bit wbs,
                                           input bit pcw, input logic [1:0] pcs);
    logic [4:0]  a;
    int          imm;
    logic [31:0] ie;
    a   = alu_on ? alu_of(m_ir) : 5'd0;
    imm = int'(m_ir[15:0]);
    if (imm >= 32768) imm = imm - 65536;
    ie  = 32'(imm);
    return {st, req, rfe, rwr, rsrc, a[4:1], a[0], mrd, mwr, wbs, pcw, pcs,
            m_err, m_ret, m_ir[20:16], m_ir[15:11], m_ir[25:21], ie};
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {state, instr_req, RegFileEnable, RegWR, RegSrc, ALUOp, ALUSrc, MemRD, MemWR,
            WBSel, PCWrite, PCSrc, err, retired, Rs, Rt, Rd, imm_ext};
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic cyc(input string name, input logic [W-1:0] e);
    logic [W-1:0] got, want;
    exp_q.push_back(e);
    @(negedge clk);
    got  = act_vec();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // One whole instruction: fwait idle fetch cycles, zero flag z, and mem_ready
  // rising after mlat MEM cycles (mlat >= TO never completes in time).
  task automatic run_instr(input logic [31:0] ins, input int fwait, input bit z,
                           input int mlat, input string name);
    logic [5:0] op;
    bit is_lw, is_sw;
    op    = ins[31:26];
    is_lw = (op == 6'd3);
    is_sw = (op == 6'd4);
    zero      = z;
    mem_ready = 1'b0;
    for (int i = 0; i < fwait; i++) begin
      instr_valid = 1'b0;
      instr       = $urandom;
      cyc({name, "/fetch_wait"}, exp_vec(F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    instr_valid = 1'b1;
    instr       = ins;
    cyc({name, "/fetch"}, exp_vec(F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    m_ir        = ins;
    instr_valid = 1'($urandom_range(0, 1));
    instr       = $urandom;

    if (op == 6'd6) begin
      cyc({name, "/dec_j"}, exp_vec(D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2));
      m_ret++;
      return;
    end
    if (op > 6'd6) begin
      cyc({name, "/dec_illegal"}, exp_vec(D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
      m_err = 1'b1;
      return;
    end
    cyc({name, "/dec"}, exp_vec(D, 1'b0, 1'b1, 1'b0, is_sw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    if (op == 6'd5) begin
      cyc({name, "/exec_beq"}, exp_vec(E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                       z ? 2'd1 : 2'd0));
      m_ret++;
      return;
    end
    cyc({name, "/exec"}, exp_vec(E, 1'b0, 1'b0, 1'b0, is_sw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    if (is_lw || is_sw) begin
      for (int k = 0; k <= TO; k++) begin
        mem_ready = (k == mlat);
        if (k == TO) begin
          cyc({name, "/mem_abort"}, exp_vec(M, 1'b0, 1'b0, 1'b0, is_sw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
          mem_ready = 1'b0;
          m_err = 1'b1;
          return;
        end else if (k == mlat) begin
          cyc({name, "/mem_done"}, exp_vec(M, 1'b0, 1'b0, 1'b0, is_sw, 1'b1, is_lw, is_sw, 1'b0, is_sw, 2'd0));
          mem_ready = 1'b0;
          if (is_sw) begin
            m_ret++;
            return;
          end
          break;
        end else begin
          cyc({name, "/mem_wait"}, exp_vec(M, 1'b0, 1'b0, 1'b0, is_sw, 1'b1, is_lw, is_sw, 1'b0, 1'b0, 2'd0));
        end
      end
    end
    cyc({name, "/wb"}, exp_vec(B, 1'b0, 1'b1, ins[25:21] != 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, is_lw, 1'b1, 2'd0));
    m_ret++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] ins;
    int          fwait;
    bit          z;
    int          mlat;
    bit          exp_ret;
    bit          exp_err;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] ret_before;
    logic [5:0]  rop;
    int          r;

    vecs[0]  = '{mk(6'h01, 5'd3, 5'd1, 16'hFFFF), 0, 1'b0, 0,  1'b1, 1'b0, "addi_neg"};
    vecs[1]  = '{mk(6'h05, 5'd2, 5'd4, 16'h0008), 1, 1'b1, 0,  1'b1, 1'b0, "beq_taken"};
    vecs[2]  = '{mk(6'h05, 5'd2, 5'd4, 16'h0008), 1, 1'b0, 0,  1'b1, 1'b0, "beq_not_taken"};
    vecs[3]  = '{mk(6'h04, 5'd5, 5'd2, 16'h0010), 0, 1'b0, 3,  1'b1, 1'b0, "sw_wait3"};
    vecs[4]  = '{mk(6'h00, 5'd0, 5'd7, 16'h4805), 0, 1'b0, 0,  1'b1, 1'b0, "rtype_rd0"};
    vecs[5]  = '{mk(6'h02, 5'd9, 5'd8, 16'h7F0F), 2, 1'b1, 0,  1'b1, 1'b0, "andi_pos"};
    vecs[6]  = '{mk(6'h03, 5'd6, 5'd1, 16'h8000), 0, 1'b0, 0,  1'b1, 1'b0, "lw_fast"};
    vecs[7]  = '{mk(6'h06, 5'd1, 5'd1, 16'h1234), 2, 1'b0, 0,  1'b1, 1'b0, "jump"};
    vecs[8]  = '{mk(6'h03, 5'd4, 5'd2, 16'h0004), 0, 1'b0, 14, 1'b1, 1'b0, "lw_last_chance"};
    vecs[9]  = '{mk(6'h3F, 5'd3, 5'd3, 16'h0000), 0, 1'b0, 0,  1'b0, 1'b1, "illegal_3f"};
    vecs[10] = '{mk(6'h03, 5'd4, 5'd2, 16'h0004), 1, 1'b0, 99, 1'b0, 1'b1, "lw_timeout"};
    vecs[11] = '{mk(6'h04, 5'd5, 5'd2, 16'h0010), 0, 1'b0, 15, 1'b0, 1'b1, "sw_ready_too_late"};

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'hDEAD_BEEF;
    mem_ready   = 1'b0;
    zero        = 1'b0;
    m_ir        = 32'd0;
    m_err       = 1'b0;
    m_ret       = 16'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", exp_vec(F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    rst_n = 1'b1;
    cyc("req_after_reset", exp_vec(F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    // directed table
    for (int i = 0; i < 12; i++) begin
      ret_before = m_ret;
      run_instr(vecs[i].ins, vecs[i].fwait, vecs[i].z, vecs[i].mlat, vecs[i].name);
      check_val({vecs[i].name, "/retired"}, 32'(retired), 32'(ret_before + 16'(vecs[i].exp_ret)));
      check_val({vecs[i].name, "/err"}, 32'(err), 32'(vecs[i].exp_err));
      check_val({vecs[i].name, "/back_to_fetch"}, 32'(state), 32'(F));
    end
    check_val("imm_ext_zero_ext_positive", imm_ext, 32'h0000_0010);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 9);
      rop = (r <= 6) ? 6'(r) : 6'($urandom_range(7, 63));
      run_instr({rop, 26'($urandom)}, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                $urandom_range(0, TO + 2), "random");
    end
    check_val("random/retired_total", 32'(retired), 32'(m_ret));

    // reset during MEM of an LW
    mem_ready   = 1'b0;
    instr_valid = 1'b1;
    instr       = mk(6'h03, 5'd7, 5'd2, 16'h0020);
    cyc("rstmem/fetch", exp_vec(F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    m_ir        = instr;
    instr_valid = 1'b0;
    cyc("rstmem/dec", exp_vec(D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("rstmem/exec", exp_vec(E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("rstmem/mem0", exp_vec(M, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    rst_n = 1'b0;
    cyc("rstmem/mem1", exp_vec(M, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    m_ir  = 32'd0;
    m_err = 1'b0;
    m_ret = 16'd0;
    cyc("rstmem/after", exp_vec(F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    rst_n = 1'b1;

    // recovery after reset
    run_instr(vecs[0].ins, 0, 1'b0, 0, "post_reset_addi");
    check_val("post_reset/retired", 32'(retired), 32'd1);
    check_val("post_reset/err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
